axis_length_cut: RTL



---
 rtl/axis_length_cut.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/axis_length_cut.sv
// axis_length_cut
// Cuts every AXI-Stream frame to a programmed beat count. The first `length`
// beats of each input frame are forwarded and the last forwarded beat carries
// tlast. The remaining input beats, up to and including the input tlast, are
// consumed and discarded. length == 0 selects pass-through for that frame.
// A frame shorter than `length` is forwarded as is and is never padded.
//
// Build option: define AXIS_LENGTH_CUT_SKID_EN to put a 2-entry skid buffer on
// the output. axis_in_tready is then a register and latency is 1 cycle.
// Without it the output is combinational from the input, with 0 cycles latency.
//
// Ports:
//   aclk, aresetn      clock; asynchronous active-low reset
//   length [31:0]      beats per output frame, sampled on each frame's first beat
//   axis_in_*          input stream (tdata, tkeep, tuser, tvalid, tready, tlast)
//   axis_out_*         output stream; tdata, tkeep and tuser pass through unchanged
module axis_length_cut #(
  parameter  int DSIZE = 8,
  localparam int KSIZE = ((DSIZE / 8) > 0) ? (DSIZE / 8) : 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [31:0]      length,
  input  logic [DSIZE-1:0] axis_in_tdata,
  input  logic [KSIZE-1:0] axis_in_tkeep,
  input  logic             axis_in_tuser,
  input  logic             axis_in_tvalid,
  output logic             axis_in_tready,
  input  logic             axis_in_tlast,
  output logic [DSIZE-1:0] axis_out_tdata,
  output logic [KSIZE-1:0] axis_out_tkeep,
  output logic             axis_out_tuser,
  output logic             axis_out_tvalid,
  input  logic             axis_out_tready,
  output logic             axis_out_tlast
);

  typedef enum logic [1:0] {SOF, PASS, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt, cnt_inc;
  logic [31:0] len_r, len_nxt;
  logic        accept;     // input beat transfers this cycle
  logic        fwd;        // current input beat goes to the output
  logic        beat_last;  // tlast to put on the forwarded beat

  // Frame cutting FSM. beat_last/fwd describe the beat currently presented,
  // whether or not it transfers; state moves only on an accepted beat.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_r;
    beat_last = axis_in_tlast;
    fwd       = 1'b1;
    // saturating increment: the count never wraps back to a small value
    cnt_inc   = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    case (state)
      SOF: begin
        if (length == 32'd0) begin
          beat_last = axis_in_tlast;
          if (accept) state_nxt = axis_in_tlast ? SOF : PASS;
        end else if (axis_in_tlast || length == 32'd1) begin
          beat_last = 1'b1;
          if (accept) state_nxt = axis_in_tlast ? SOF : DROP;
        end else begin
          beat_last = 1'b0;
          if (accept) state_nxt = PASS;
        end
        if (accept) begin
          len_nxt = length;
          cnt_nxt = 32'd1;
        end
      end
      PASS: begin
        if (axis_in_tlast) begin
          beat_last = 1'b1;
          if (accept) state_nxt = SOF;
        end else if (len_r != 32'd0 && cnt_inc == len_r) begin
          // len_r == 0 is pass-through: the counter never cuts
          beat_last = 1'b1;
          if (accept) state_nxt = DROP;
        end else begin
          beat_last = 1'b0;
        end
        if (accept) cnt_nxt = cnt_inc;
      end
      DROP: begin
        fwd = 1'b0;
        if (accept && axis_in_tlast) state_nxt = SOF;
      end
      default: begin
        fwd       = 1'b0;
        state_nxt = SOF;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= SOF;
      cnt   <= 32'd0;
      len_r <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      len_r <= len_nxt;
    end
  end

`ifdef AXIS_LENGTH_CUT_SKID_EN

  typedef struct packed {
    logic [DSIZE-1:0] tdata;
    logic [KSIZE-1:0] tkeep;
    logic             tuser;
    logic             tlast;
  } beat_t;

  beat_t in_beat, o_beat, s_beat;
  logic  o_valid, s_valid, s_valid_nxt;
  logic  tready_r, push;

  assign accept = axis_in_tvalid & tready_r;
  assign push   = accept & fwd;

  always_comb begin
    in_beat.tdata = axis_in_tdata;
    in_beat.tkeep = axis_in_tkeep;
    in_beat.tuser = axis_in_tuser;
    in_beat.tlast = beat_last;
  end

  // A push only happens while the skid slot is empty (tready_r was derived from
  // it), so draining the slot and pushing never coincide.
  always_comb begin
    s_valid_nxt = s_valid;
    if (axis_out_tready || !o_valid) s_valid_nxt = 1'b0;
    else if (push)                   s_valid_nxt = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      o_beat   <= '0;
      s_beat   <= '0;
      o_valid  <= 1'b0;
      s_valid  <= 1'b0;
      tready_r <= 1'b0;
    end else begin
      if (axis_out_tready || !o_valid) begin
        if (s_valid) begin
          o_beat  <= s_beat;
          o_valid <= 1'b1;
        end else begin
          o_valid <= push;
          if (push) o_beat <= in_beat;
        end
      end else if (push) begin
        s_beat <= in_beat;
      end
      s_valid  <= s_valid_nxt;
      // DROP swallows beats without touching the buffer, so it never stalls
      tready_r <= (state_nxt == DROP) | ~s_valid_nxt;
    end
  end

  assign axis_in_tready  = tready_r;
  assign axis_out_tvalid = o_valid;
  assign axis_out_tdata  = o_beat.tdata;
  assign axis_out_tkeep  = o_beat.tkeep;
  assign axis_out_tuser  = o_beat.tuser;
  assign axis_out_tlast  = o_beat.tlast;

`else

  // Combinational path; aresetn gating holds outputs at their reset values
  // while reset is asserted.
  assign axis_in_tready  = aresetn & ((state == DROP) | axis_out_tready);
  assign accept          = axis_in_tvalid & axis_in_tready;
  assign axis_out_tvalid = aresetn & axis_in_tvalid & fwd;
  assign axis_out_tdata  = aresetn ? axis_in_tdata : '0;
  assign axis_out_tkeep  = aresetn ? axis_in_tkeep : '0;
  assign axis_out_tuser  = aresetn & axis_in_tuser;
  assign axis_out_tlast  = aresetn & beat_last;

`endif

endmodule
